// File: rtl/counter_ctl.sv
// Up/down loadable counter with programmable limit and wrap/saturate/one-shot overflow modes.
// Define COUNTER_PRESCALE_EN to add the div input and an enable prescaler.
module counter_ctl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] div,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic {ARMED, DONE} ctlState_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    ctlState_t        state;
    logic             tick;
    logic             atTerm;
    logic [WIDTH-1:0] clippedLoad;

    // Up-terminal uses >= so a limit lowered below the current count still terminates.
    assign atTerm      = dir ? (count >= limit) : (count == '0);
    assign clippedLoad = (load_value > limit) ? limit : load_value;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescCnt;
    logic [PRESCALE_W-1:0] periodDiv;
    logic [PRESCALE_W-1:0] effDiv;

    // div is captured at the start of each period so a change only applies to the next one.
    assign effDiv = (prescCnt == '0) ? div : periodDiv;
    assign tick   = (prescCnt == effDiv);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            prescCnt  <= '0;
            periodDiv <= '0;
        end else if (en && state == ARMED) begin
            periodDiv <= effDiv;
            if (tick) begin
                prescCnt <= '0;
            end else begin
                prescCnt <= prescCnt + 1'b1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= ARMED;
        end else if (load) begin
            count <= clippedLoad;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= ARMED;
        end else if (state == DONE) begin
            tc <= 1'b0;
            if (mode != MODE_ONESHOT) begin
                state <= ARMED;
                done  <= 1'b0;
            end
        end else if (en && tick) begin
            if (!atTerm) begin
                count <= dir ? count + 1'b1 : count - 1'b1;
                tc    <= 1'b0;
            end else begin
                tc <= 1'b1;
                case (mode)
                    MODE_SAT: begin
                        count <= dir ? limit : '0;
                    end
                    MODE_ONESHOT: begin
                        count <= dir ? limit : '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    default: begin
                        count <= dir ? '0 : limit;
                    end
                endcase
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule
